// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/sequencing controller for the 5-stage pipeline; optional stall counter under HAZ_PERF_CNT_EN
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             br_taken,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_is_mul,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             ifid_flush,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The first frozen cycle happens in RUN, so the counter only has to cover the rest.
  localparam int          RELOAD_I   = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [3:0]  MUL_RELOAD = RELOAD_I[3:0];
  localparam logic        MUL_MULTI  = (MUL_LAT > 1);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic ld_haz;
  logic mul_start;
  logic freeze;

  // Hazard detection; XZR is never a real producer so it cannot cause a stall.
  always_comb begin
    ld_haz = ex_valid & ex_memread & (ex_rd != 5'd31) & id_valid &
             ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));
    mul_start = (state_q == RUN) & ex_valid & ex_is_mul & MUL_MULTI;
    freeze    = mul_start | ((state_q == MUL_WAIT) & (cnt_q != 4'd0));
  end

  // State and multiply down-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus stage controls; freeze outranks load-use, which outranks branch flush.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ifid_flush   = 1'b0;
    mul_busy     = (state_q == MUL_WAIT);

    case (state_q)
      RUN: begin
        if (mul_start) begin
          state_d = MUL_WAIT;
          cnt_d   = MUL_RELOAD;
        end
      end
      MUL_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Release cycle: the multiply moves on to MEM and is not re-triggered.
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if (ld_haz) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (br_taken & id_valid) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rn, id_uses_rm, br_taken;
  logic [4:0]       id_rn, id_rm, ex_rd;
  logic             ex_valid, ex_memread, ex_is_mul;
  logic             pc_en, ifid_en, idex_en, idex_bubble, exmem_bubble, ifid_flush, mul_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .br_taken(br_taken),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_is_mul(ex_is_mul),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_bubble(exmem_bubble), .ifid_flush(ifid_flush), .mul_busy(mul_busy),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: position inside a multiply window (1..MUL_LAT, 0 = none) and a stall tally.
  int m_pos = 0;
  int m_cnt = 0;
  int k;
  bit in_win, frz, haz;
  bit e_pc, e_ifid, e_idex, e_idb, e_exb, e_fl, e_busy;

  always_comb begin
    in_win = (m_pos != 0) || (ex_valid && ex_is_mul && (MUL_LAT > 1));
    k      = (m_pos != 0) ? m_pos : 1;
    frz    = in_win && (k <= MUL_LAT - 1);
    haz    = ex_valid && ex_memread && (ex_rd != 5'd31) && id_valid &&
             ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    e_busy = (m_pos >= 2);
    e_pc   = !(frz || haz);
    e_ifid = e_pc;
    e_idex = !frz;
    e_exb  = frz;
    e_idb  = !frz && haz;
    e_fl   = !frz && !haz && br_taken && id_valid;
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_pos <= 0;
      m_cnt <= 0;
    end else begin
      m_pos <= (in_win && k < MUL_LAT) ? k + 1 : 0;
      if (!e_pc && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_en", int'(pc_en), int'(e_pc));
      chk("ifid_en", int'(ifid_en), int'(e_ifid));
      chk("idex_en", int'(idex_en), int'(e_idex));
      chk("idex_bubble", int'(idex_bubble), int'(e_idb));
      chk("exmem_bubble", int'(exmem_bubble), int'(e_exb));
      chk("ifid_flush", int'(ifid_flush), int'(e_fl));
      chk("mul_busy", int'(mul_busy), int'(e_busy));
`ifdef HAZ_PERF_CNT_EN
      chk("stall_cnt", int'(stall_cnt), m_cnt);
`else
      chk("stall_cnt", int'(stall_cnt), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0; br_taken = 0;
    ex_valid = 0; ex_rd = 0; ex_memread = 0; ex_is_mul = 0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    reset = 1'b1;

    @(negedge clk);
    chk("rst_pc_en", int'(pc_en), 1);
    chk("rst_idex_en", int'(idex_en), 1);
    chk("rst_mul_busy", int'(mul_busy), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    tick();

    // Load X1 in EX, ADD in decode reads X1.
    ex_valid = 1; ex_memread = 1; ex_rd = 1;
    id_valid = 1; id_uses_rn = 1; id_rn = 1;
    @(negedge clk);
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_ifid_en", int'(ifid_en), 0);
    chk("lu_idex_bubble", int'(idex_bubble), 1);
    chk("lu_idex_en", int'(idex_en), 1);
    tick();
    ex_memread = 0; ex_rd = 2; id_rn = 3;
    @(negedge clk);
    chk("lu_after_pc_en", int'(pc_en), 1);
    chk("lu_after_bubble", int'(idex_bubble), 0);
    tick();

    // XZR never stalls.
    ex_memread = 1; ex_rd = 31; id_rn = 31; id_uses_rm = 1; id_rm = 31;
    @(negedge clk);
    chk("xzr_pc_en", int'(pc_en), 1);
    tick();

    // Dependence through rm, then same regs with rm unused.
    ex_rd = 5; id_rm = 5; id_rn = 0;
    @(negedge clk);
    chk("rm_pc_en", int'(pc_en), 0);
    tick();
    id_uses_rm = 0;
    @(negedge clk);
    chk("rm_unused_pc_en", int'(pc_en), 1);
    tick();

    // Branch together with load-use, then alone, then with no valid decode.
    id_uses_rn = 1; id_rn = 5; br_taken = 1;
    @(negedge clk);
    chk("br_haz_pc_en", int'(pc_en), 0);
    chk("br_haz_flush", int'(ifid_flush), 0);
    tick();
    ex_memread = 0;
    @(negedge clk);
    chk("br_flush", int'(ifid_flush), 1);
    chk("br_pc_en", int'(pc_en), 1);
    tick();
    id_valid = 0;
    @(negedge clk);
    chk("br_noid_flush", int'(ifid_flush), 0);
    tick();

    // Back-to-back multiplies, with a load-use pattern also present during the freeze.
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ex_valid = 1; ex_is_mul = 1; id_valid = 1; id_uses_rn = 1; id_rn = 7; ex_rd = 7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul_pc_en", int'(pc_en), int'(i % 4 == 3));
      chk("mul_busy_seq", int'(mul_busy), int'(i % 4 != 0));
      chk("mul_exmem_bubble", int'(exmem_bubble), int'(i % 4 != 3));
      chk("mul_idex_bubble", int'(idex_bubble), 0);
      tick();
    end
    idle();
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    chk("mul_stall_cnt", int'(stall_cnt), 6);
`endif
    tick();

    // Reset while MUL_WAIT has cnt==1.
    ex_valid = 1; ex_is_mul = 1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", int'(mul_busy), 1);
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_busy_after", int'(mul_busy), 0);
    chk("mid_stall_cnt", int'(stall_cnt), 0);
    chk("mid_pc_en", int'(pc_en), 1);
    tick();

`ifdef HAZ_PERF_CNT_EN
    // Hold a load-use stall long enough to saturate the counter.
    ex_valid = 1; ex_memread = 1; ex_rd = 1; id_valid = 1; id_uses_rn = 1; id_rn = 1;
    repeat (CNT_MAX + 5) tick();
    @(negedge clk);
    chk("sat_stall_cnt", int'(stall_cnt), CNT_MAX);
    idle();
    tick();
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
